// File: rtl/temporal_avg_pool.sv
// Streaming temporal average pool: sliding window of POOL_SIZE accepted samples,
// emitting the rounded window mean every STRIDE samples once the window is full.
module temporal_avg_pool #(
  parameter int DATA_WIDTH = 16,
  parameter int POOL_SIZE  = 4,
  parameter int STRIDE     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         x_valid,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         y_valid
);

  localparam int SHIFT     = $clog2(POOL_SIZE);
  localparam int SUM_WIDTH = DATA_WIDTH + SHIFT + 1;
  localparam int EXT_W     = SUM_WIDTH - DATA_WIDTH;
  localparam int FILL_W    = $clog2(POOL_SIZE + 1);
  localparam int STR_W     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(POOL_SIZE);
  localparam logic [STR_W-1:0]  STR_RELOAD = STR_W'(STRIDE - 1);

  logic signed [DATA_WIDTH-1:0] win_q    [POOL_SIZE];
  logic signed [DATA_WIDTH-1:0] win_base [POOL_SIZE];
  logic signed [DATA_WIDTH-1:0] win_d    [POOL_SIZE];

  logic signed [SUM_WIDTH-1:0]  sum_q, sum_base, sum_d;
  logic signed [SUM_WIDTH-1:0]  x_ext, old_ext;
  logic [FILL_W-1:0]            fill_q, fill_base, fill_d;
  logic [STR_W-1:0]             stride_q, stride_base, stride_d;
  logic signed [DATA_WIDTH-1:0] y_out_q, y_out_d, y_mean;
  logic                         y_valid_q, y_valid_d;
  logic                         full, advance, emit;
  logic                         unused_mean;

  // clear is folded in as an emptied "base" state, so a sample arriving with
  // clear lands as the first element of the new window.
  generate
    for (genvar gi = 0; gi < POOL_SIZE; gi++) begin : g_win
      assign win_base[gi] = clear ? '0 : win_q[gi];
      if (gi == 0) begin : g_head
        assign win_d[gi] = x_valid ? x_in : win_base[gi];
      end else begin : g_tail
        assign win_d[gi] = x_valid ? win_base[gi-1] : win_base[gi];
      end

      always_ff @(posedge clk) begin
        if (rst) win_q[gi] <= '0;
        else     win_q[gi] <= win_d[gi];
      end
    end
  endgenerate

  assign sum_base    = clear ? '0 : sum_q;
  assign fill_base   = clear ? '0 : fill_q;
  assign stride_base = clear ? '0 : stride_q;

  assign x_ext   = {{EXT_W{x_in[DATA_WIDTH-1]}}, x_in};
  assign old_ext = {{EXT_W{win_base[POOL_SIZE-1][DATA_WIDTH-1]}}, win_base[POOL_SIZE-1]};

  always_comb begin
    sum_d    = sum_base;
    fill_d   = fill_base;
    stride_d = stride_base;
    if (x_valid) begin
      sum_d = sum_base + x_ext - old_ext;
      if (fill_base != FILL_FULL) fill_d = fill_base + FILL_W'(1);
    end
    full    = (fill_d == FILL_FULL);
    advance = x_valid && full;
    emit    = advance && (stride_base == '0);
    if (advance) stride_d = emit ? STR_RELOAD : stride_base - STR_W'(1);
  end

  // Mean rounds half toward +inf; the shifted value always fits DATA_WIDTH.
  generate
    if (SHIFT == 0) begin : g_nodiv
      assign y_mean      = sum_d[DATA_WIDTH-1:0];
      assign unused_mean = sum_d[SUM_WIDTH-1];
    end else begin : g_div
      localparam logic signed [SUM_WIDTH-1:0] HALF = SUM_WIDTH'(1) << (SHIFT - 1);
      logic signed [SUM_WIDTH-1:0] rounded;
      assign rounded     = sum_d + HALF;
      assign y_mean      = rounded[SHIFT +: DATA_WIDTH];
      assign unused_mean = ^{rounded[SUM_WIDTH-1], rounded[SHIFT-1:0]};
    end
  endgenerate

  assign y_out_d   = emit ? y_mean : y_out_q;
  assign y_valid_d = emit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      fill_q    <= '0;
      stride_q  <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      fill_q    <= fill_d;
      stride_q  <= stride_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_temporal_avg_pool.sv
// Bench for temporal_avg_pool: two instances (STRIDE 4 and 2, POOL_SIZE 4)
// checked every cycle against a queue-based model of the pooling rules.
module tb_temporal_avg_pool;

  logic               clk = 1'b0;
  logic               rst, clear, x_valid;
  logic signed [15:0] x_in;
  logic signed [15:0] y4, y2;
  logic               v4, v2;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: accepted samples since restart, and last emitted values.
  int   hist[$];
  int   nacc;
  int   ey4, ey2;
  logic ev4, ev2;

  always #5 clk = ~clk;

  temporal_avg_pool #(.DATA_WIDTH(16), .POOL_SIZE(4), .STRIDE(4)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear), .x_in(x_in), .x_valid(x_valid),
    .y_out(y4), .y_valid(v4));

  temporal_avg_pool #(.DATA_WIDTH(16), .POOL_SIZE(4), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .x_in(x_in), .x_valid(x_valid),
    .y_out(y2), .y_valid(v2));

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Drive one clock of stimulus and advance the model to match.
  task automatic cycle(input logic r, input logic c, input logic v, input int x);
    int s, m;
    rst = r; clear = c; x_valid = v; x_in = 16'(x);
    @(posedge clk);
    #1;
    ev4 = 1'b0;
    ev2 = 1'b0;
    if (r) begin
      hist.delete(); nacc = 0; ey4 = 0; ey2 = 0;
    end else begin
      if (c) begin
        hist.delete(); nacc = 0;
      end
      if (v) begin
        hist.push_back(int'(signed'(16'(x))));
        nacc++;
        if (hist.size() > 4) void'(hist.pop_front());
        if (nacc >= 4) begin
          s = 0;
          foreach (hist[k]) s += hist[k];
          m = floor_div(s + 2, 4);
          n_cmp++;
          if (m < -32768 || m > 32767) begin
            n_bad++;
            $display("FAIL mean_range: mean %0d, required within 16-bit signed", m);
          end
          if ((nacc - 4) % 4 == 0) begin ev4 = 1'b1; ey4 = m; end
          if ((nacc - 4) % 2 == 0) begin ev2 = 1'b1; ey2 = m; end
        end
      end
    end
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 123);
    n_cmp += 2;
    if (v4 !== 1'b0 || y4 !== 16'sd0) begin
      n_bad++; $display("FAIL reset_s4: got v=%0b y=%0d, want v=0 y=0", v4, y4);
    end
    if (v2 !== 1'b0 || y2 !== 16'sd0) begin
      n_bad++; $display("FAIL reset_s2: got v=%0b y=%0d, want v=0 y=0", v2, y2);
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_ramp();
    int got4[$], got2[$];
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, i);
      n_cmp += 2;
      if (v4 !== ev4 || y4 !== 16'(ey4)) begin
        n_bad++; $display("FAIL ramp_s4 x=%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v4, y4, ev4, ey4);
      end
      if (v2 !== ev2 || y2 !== 16'(ey2)) begin
        n_bad++; $display("FAIL ramp_s2 x=%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v2, y2, ev2, ey2);
      end
      if (v4 === 1'b1) got4.push_back(int'(y4));
      if (v2 === 1'b1) got2.push_back(int'(y2));
    end
    n_cmp += 2;
    if (got4.size() != 2 || got4[0] != 3 || got4[1] != 7) begin
      n_bad++; $display("FAIL ramp_s4_list: got %p, want '{3, 7}", got4);
    end
    if (got2.size() != 3 || got2[0] != 3 || got2[1] != 5 || got2[2] != 7) begin
      n_bad++; $display("FAIL ramp_s2_list: got %p, want '{3, 5, 7}", got2);
    end
  endtask

  task automatic test_extremes();
    int seq[12] = '{-1, -1, -1, -2, 32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
    int want[3] = '{-1, 32767, -32768};
    int got4[$];
    cycle(1, 0, 0, 0);
    foreach (seq[i]) begin
      cycle(0, 0, 1, seq[i]);
      n_cmp += 2;
      if (v4 !== ev4 || y4 !== 16'(ey4)) begin
        n_bad++; $display("FAIL extreme_s4 #%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v4, y4, ev4, ey4);
      end
      if (v2 !== ev2 || y2 !== 16'(ey2)) begin
        n_bad++; $display("FAIL extreme_s2 #%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v2, y2, ev2, ey2);
      end
      if (v4 === 1'b1) got4.push_back(int'(y4));
    end
    n_cmp++;
    if (got4.size() != 3 || got4[0] != want[0] || got4[1] != want[1] || got4[2] != want[2]) begin
      n_bad++; $display("FAIL extreme_list: got %p, want '{-1, 32767, -32768}", got4);
    end
  endtask

  task automatic test_gapped();
    int got4[$];
    int x = 1;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin cycle(0, 0, 1, x); x++; end
      else cycle(0, 0, 0, 999);
      n_cmp += 2;
      if (v4 !== ev4 || y4 !== 16'(ey4)) begin
        n_bad++; $display("FAIL gap_s4 cyc=%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v4, y4, ev4, ey4);
      end
      if (v2 !== ev2 || y2 !== 16'(ey2)) begin
        n_bad++; $display("FAIL gap_s2 cyc=%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v2, y2, ev2, ey2);
      end
      if (v4 === 1'b1) got4.push_back(int'(y4));
    end
    n_cmp++;
    if (got4.size() != 2 || got4[0] != 3 || got4[1] != 7) begin
      n_bad++; $display("FAIL gap_list: got %p, want '{3, 7}", got4);
    end
  endtask

  task automatic test_clear();
    // Columns: clear, x_valid, x
    int stim[12][3] = '{'{0,1,1}, '{0,1,2}, '{1,1,10}, '{0,1,10}, '{0,1,10}, '{0,1,10},
                        '{1,0,0}, '{0,1,5}, '{0,1,5}, '{0,1,5}, '{0,0,0}, '{0,1,5}};
    int pulses = 0;
    cycle(1, 0, 0, 0);
    foreach (stim[i]) begin
      cycle(0, stim[i][0][0], stim[i][1][0], stim[i][2]);
      n_cmp += 2;
      if (v4 !== ev4 || y4 !== 16'(ey4)) begin
        n_bad++; $display("FAIL clear_s4 step=%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v4, y4, ev4, ey4);
      end
      if (v2 !== ev2 || y2 !== 16'(ey2)) begin
        n_bad++; $display("FAIL clear_s2 step=%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v2, y2, ev2, ey2);
      end
      if (v4 === 1'b1) pulses++;
      if (i == 5) begin
        n_cmp++;
        if (v4 !== 1'b1 || y4 !== 16'sd10) begin
          n_bad++; $display("FAIL clear_first: got v=%0b y=%0d, want v=1 y=10", v4, y4);
        end
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++; $display("FAIL clear_pulses: got %0d, want 2", pulses);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 9);
    cycle(1, 0, 1, 9);
    n_cmp++;
    if (v4 !== 1'b0 || y4 !== 16'sd0 || v2 !== 1'b0 || y2 !== 16'sd0) begin
      n_bad++; $display("FAIL reset_mid: got v4=%0b y4=%0d v2=%0b y2=%0d, want all 0", v4, y4, v2, y2);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 4);
      n_cmp += 2;
      if (v4 !== ev4 || y4 !== 16'(ey4)) begin
        n_bad++; $display("FAIL rstmid_s4 #%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v4, y4, ev4, ey4);
      end
      if (v2 !== ev2 || y2 !== 16'(ey2)) begin
        n_bad++; $display("FAIL rstmid_s2 #%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v2, y2, ev2, ey2);
      end
    end
    n_cmp++;
    if (v4 !== 1'b1 || y4 !== 16'sd4) begin
      n_bad++; $display("FAIL rstmid_value: got v=%0b y=%0d, want v=1 y=4", v4, y4);
    end
  endtask

  task automatic test_random();
    logic r, c, v;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      cycle(r, c, v, int'(signed'(16'($urandom))));
      n_cmp += 2;
      if (v4 !== ev4 || y4 !== 16'(ey4)) begin
        n_bad++; $display("FAIL rand_s4 cyc=%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v4, y4, ev4, ey4);
      end
      if (v2 !== ev2 || y2 !== 16'(ey2)) begin
        n_bad++; $display("FAIL rand_s2 cyc=%0d: got v=%0b y=%0d, want v=%0b y=%0d", i, v2, y2, ev2, ey2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; x_valid = 1'b0; x_in = '0;
    nacc = 0; ey4 = 0; ey2 = 0; ev4 = 1'b0; ev2 = 1'b0;
    test_reset();
    test_ramp();
    test_extremes();
    test_gapped();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/temporal_avg_pool.md
Name: temporal_avg_pool

Overview:
- Streaming 1D temporal average-pooling stage that sits directly downstream of the temporal convolution. It consumes that stage's signed sample stream and its valid strobe.
- Keeps a sliding window of the last POOL_SIZE accepted samples. Every STRIDE accepted samples, once the window is full, it emits the rounded mean of the window.
- Valid-only interface with no backpressure, matching the upstream convolution output.

Parameters:
- DATA_WIDTH, 16, width of signed input and output samples.
- POOL_SIZE, 4, window length in samples; power of two, 1..64.
- STRIDE, 4, accepted samples between successive outputs once the window is full; 1..POOL_SIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- clear  in  1  synchronous segment restart; empties the window and counters.
- x_in  in  DATA_WIDTH  signed input sample.
- x_valid  in  1  x_in is accepted this cycle.
- y_out  out  DATA_WIDTH  signed pooled sample.
- y_valid  out  1  one-cycle strobe qualifying y_out.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Window registers, running sum, fill_cnt, stride_cnt, y_out and y_valid all go to 0.
  - rst overrides clear and x_valid. Asserting it mid-window discards all partial state.
- Internal derived values:
  - SHIFT = log2(POOL_SIZE).
  - SUM_WIDTH = DATA_WIDTH + SHIFT + 1; the running sum is signed, is never truncated, and cannot overflow.
- Window update on an accepted sample (x_valid=1):
  - Sample enters win[0]; win[i] <= win[i-1]; the oldest sample win[POOL_SIZE-1] is discarded.
  - sum_next = sum + x_in - win[POOL_SIZE-1]. Empty slots hold 0.
- fill_cnt: counts accepted samples from 0 and saturates at POOL_SIZE. The window is full when fill_cnt_next == POOL_SIZE.
- Emission rule, per accepted sample, when the window is full (using fill_cnt_next):
  - If stride_cnt == 0: emit, then stride_cnt <= STRIDE-1.
  - Otherwise: stride_cnt <= stride_cnt-1.
  - While the window is not full, stride_cnt holds 0, so the first emission happens exactly on the POOL_SIZE-th sample.
- Output arithmetic:
  - y_out = (sum_next + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift (round half toward +inf). When POOL_SIZE=1, y_out = sum_next.
  - The result always fits DATA_WIDTH, so there is no saturation. The bench asserts the dropped upper bits equal the sign bit.
- Timing:
  - Latency is 1 cycle: a sample accepted at edge T that triggers an emission gives y_valid=1 and y_out valid during cycle T+1.
  - y_valid is high for exactly one cycle per emission.
  - y_out holds its last value while y_valid=0.
- Throughput: one sample per cycle. Gaps in x_valid stall all state; no output is produced during a gap.
- clear (synchronous, priority below rst):
  - Clears window, sum, fill_cnt and stride_cnt; y_valid=0 unless the rule below emits.
  - clear together with x_valid: the incoming sample becomes the first sample of the new window (fill_cnt=1, sum=x_in). It emits only if POOL_SIZE==1.
  - clear does not alter y_out.
- Overlap: STRIDE < POOL_SIZE gives overlapping windows; STRIDE == POOL_SIZE gives disjoint windows.

Test Plan:
- POOL_SIZE=4, STRIDE=4, continuous x_valid, x = 1..8 -> exactly two y_valid pulses, one cycle after the 4th and 8th samples, with y_out = 3 then 7 ((10+2)>>2, (26+2)>>2).
- POOL_SIZE=4, STRIDE=2, x = 1..8 -> outputs after samples 4, 6, 8 with y_out = 3, 5, 7; no pulse after samples 5 and 7.
- Sign, rounding and extremes, POOL_SIZE=4 -> {-1,-1,-1,-2} gives y_out=-1; four 32767 give 32767; four -32768 give -32768.
- Gapped stream: x = 1..8 with x_valid on alternate cycles -> identical outputs (3, 7), each one cycle after its triggering sample; y_valid=0 during gaps.
- Clear mid-window: feed 1,2; then clear=1 with x_valid=1, x=10; then 10,10,10 -> no output before the 4th sample of the new window, then y_out = 10. clear alone with x_valid=0 -> next output needs 4 new samples.
- Reset mid-operation: after 3 samples of a window, rst=1 for one cycle -> y_out=0, y_valid=0, and the following 4 samples 4,4,4,4 give y_out=4 with no contribution from pre-reset data.
